block_checker_nested: RTL and testbench



---
 rtl/block_checker_pkg.sv | 66 ++++++
 rtl/block_word_matcher.sv | 64 ++++++
 rtl/block_checker_nested.sv | 134 +++++++++++++
 tb/tb_block_checker_nested.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/block_checker_pkg.sv
// rtl/block_checker_pkg.sv - shared encodings and keyword tables for the nesting checker
// Keyword text is stored left-justified in 64-bit words so any character index is in range.
package block_checker_pkg;

  typedef enum logic [2:0] {
    KW_NONE    = 3'd0,
    KW_BEGIN   = 3'd1,
    KW_END     = 3'd2,
    KW_CASE    = 3'd3,
    KW_ENDCASE = 3'd4
  } kw_id_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_UNDERFLOW = 2'b01,
    ERR_MISMATCH  = 2'b10,
    ERR_OVERFLOW  = 2'b11
  } err_code_e;

  localparam logic TYPE_BEGIN = 1'b0;
  localparam logic TYPE_CASE  = 1'b1;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [3:0] WORD_LEN_MAX = 4'd8;

  localparam logic [63:0] STR_BEGIN   = {"begin", 24'h0};
  localparam logic [63:0] STR_END     = {"end", 40'h0};
  localparam logic [63:0] STR_CASE    = {"case", 32'h0};
  localparam logic [63:0] STR_ENDCASE = {"endcase", 8'h0};

  typedef struct packed {
    logic      err;
    err_code_e code;
    logic      push;
    logic      pop;
    logic      push_type;
  } action_t;

  function automatic logic [3:0] kw_len(kw_id_e kw);
    case (kw)
      KW_BEGIN:   return 4'd5;
      KW_END:     return 4'd3;
      KW_CASE:    return 4'd4;
      KW_ENDCASE: return 4'd7;
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] kw_char(kw_id_e kw, logic [2:0] idx);
    logic [63:0] s;
    case (kw)
      KW_BEGIN:   s = STR_BEGIN;
      KW_END:     s = STR_END;
      KW_CASE:    s = STR_CASE;
      KW_ENDCASE: s = STR_ENDCASE;
      default:    s = '0;
    endcase
    s = s << {idx, 3'b000};
    return s[63:56];
  endfunction

  function automatic logic [7:0] fold_char(logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/block_word_matcher.sv
// rtl/block_word_matcher.sv - space-delimited word tracker that recognises the nesting keywords
// Keeps a saturating length and one "still matching" flag per keyword slot.
module block_word_matcher
  import block_checker_pkg::*;
#(
  parameter bit ENABLE_CASE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in,
  output kw_id_e     pending_kw,
  output logic       word_nonempty,
  output logic       commit
);

  logic [3:0] len_q, len_d;
  logic [3:0] match_q, match_d;
  logic [7:0] ch;

  always_comb begin
    ch      = fold_char(in);
    len_d   = len_q;
    match_d = match_q;
    if (in_valid) begin
      if (in == CHAR_SPACE) begin
        len_d   = '0;
        match_d = '1;
      end else begin
        len_d = (len_q == WORD_LEN_MAX) ? len_q : len_q + 4'd1;
        for (int k = 0; k < 4; k++) begin
          match_d[k] = match_q[k]
                     && (len_q < kw_len(kw_id_e'(3'(k + 1))))
                     && (ch == kw_char(kw_id_e'(3'(k + 1)), len_q[2:0]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      match_q <= '1;
    end else begin
      len_q   <= len_d;
      match_q <= match_d;
    end
  end

  // Keyword lengths are all distinct, so at most one slot can hit.
  always_comb begin
    pending_kw = KW_NONE;
    for (int k = 0; k < 4; k++) begin
      if (match_q[k] && (len_q == kw_len(kw_id_e'(3'(k + 1))))
          && (ENABLE_CASE || k < 2)) begin
        pending_kw = kw_id_e'(3'(k + 1));
      end
    end
  end

  assign word_nonempty = (len_q != '0);
  assign commit        = in_valid && (in == CHAR_SPACE) && word_nonempty;

endmodule

// File: rtl/block_checker_nested.sv
// rtl/block_checker_nested.sv - begin/end and case/endcase nesting checker with sticky errors
// The same action decode drives both the commit and the combinational result lookahead.
module block_checker_nested
  import block_checker_pkg::*;
#(
  parameter int MAX_DEPTH   = 16,
  parameter int CNT_W       = 5,
  parameter bit ENABLE_CASE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             result,
  output logic [CNT_W-1:0] depth,
  output logic             error,
  output logic [1:0]       err_code
);

  kw_id_e     pending_kw;
  logic       word_nonempty;
  logic       commit;

  logic [MAX_DEPTH-1:0] stack_q, stack_d;
  logic [CNT_W-1:0]     depth_q, depth_d;
  logic                 error_q, error_d;
  err_code_e            code_q, code_d;
  logic                 top_type;
  action_t              act;

  block_word_matcher #(
    .ENABLE_CASE(ENABLE_CASE)
  ) u_matcher (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in           (in),
    .pending_kw   (pending_kw),
    .word_nonempty(word_nonempty),
    .commit       (commit)
  );

  function automatic action_t decide(kw_id_e kw, logic [CNT_W-1:0] d, logic top);
    action_t a;
    logic    want;
    a    = '0;
    want = (kw == KW_ENDCASE) ? TYPE_CASE : TYPE_BEGIN;
    case (kw)
      KW_BEGIN, KW_CASE: begin
        if (d == CNT_W'(MAX_DEPTH)) begin
          a.err  = 1'b1;
          a.code = ERR_OVERFLOW;
        end else begin
          a.push      = 1'b1;
          a.push_type = (kw == KW_CASE) ? TYPE_CASE : TYPE_BEGIN;
        end
      end
      KW_END, KW_ENDCASE: begin
        if (d == '0) begin
          a.err  = 1'b1;
          a.code = ERR_UNDERFLOW;
        end else if (top != want) begin
          a.err  = 1'b1;
          a.code = ERR_MISMATCH;
        end else begin
          a.pop = 1'b1;
        end
      end
      default: ;
    endcase
    return a;
  endfunction

  always_comb begin
    top_type = TYPE_BEGIN;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (depth_q == CNT_W'(i + 1)) top_type = stack_q[i];
    end
  end

  assign act = decide(pending_kw, depth_q, top_type);

  always_comb begin
    stack_d = stack_q;
    depth_d = depth_q;
    error_d = error_q;
    code_d  = code_q;
    if (commit && !error_q) begin
      if (act.err) begin
        error_d = 1'b1;
        code_d  = act.code;
      end else if (act.push) begin
        for (int i = 0; i < MAX_DEPTH; i++) begin
          if (depth_q == CNT_W'(i)) stack_d[i] = act.push_type;
        end
        depth_d = depth_q + 1'b1;
      end else if (act.pop) begin
        depth_d = depth_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stack_q <= '0;
      depth_q <= '0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      stack_q <= stack_d;
      depth_q <= depth_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  // Lookahead: treat a non-empty pending word as committed; a push can never end at depth 0.
  always_comb begin
    result = 1'b0;
    if (!error_q) begin
      if (word_nonempty) begin
        result = !act.err && !act.push
               && (act.pop ? (depth_q == CNT_W'(1)) : (depth_q == '0));
      end else begin
        result = (depth_q == '0);
      end
    end
  end

  assign depth    = depth_q;
  assign error    = error_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_block_checker_nested.sv
// tb/tb_block_checker_nested.sv - randomized and directed bench for the nesting checker
// Three instances (default, MAX_DEPTH=2, ENABLE_CASE=0) share one input stream.
module tb_block_checker_nested;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_b = 8'h00;

  logic       res_w  [3];
  logic [4:0] dep_w  [3];
  logic       err_w  [3];
  logic [1:0] code_w [3];

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  block_checker_nested #(.MAX_DEPTH(16), .CNT_W(5), .ENABLE_CASE(1'b1)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
    .result(res_w[0]), .depth(dep_w[0]), .error(err_w[0]), .err_code(code_w[0]));
  block_checker_nested #(.MAX_DEPTH(2), .CNT_W(5), .ENABLE_CASE(1'b1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
    .result(res_w[1]), .depth(dep_w[1]), .error(err_w[1]), .err_code(code_w[1]));
  block_checker_nested #(.MAX_DEPTH(16), .CNT_W(5), .ENABLE_CASE(1'b0)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b),
    .result(res_w[2]), .depth(dep_w[2]), .error(err_w[2]), .err_code(code_w[2]));

  // Reference model: current word as a byte queue, per-instance stack as a bit array.
  logic [7:0]  wq[$];
  int          md  [3];
  logic [31:0] mst [3];
  bit          me  [3];
  logic [1:0]  mc  [3];

  function automatic int maxd_of(int inst);
    return (inst == 1) ? 2 : 16;
  endfunction

  function automatic bit ecase_of(int inst);
    return inst != 2;
  endfunction

  function automatic logic [7:0] lc(logic [7:0] c);
    return (c >= 8'd65 && c <= 8'd90) ? c + 8'd32 : c;
  endfunction

  function automatic bit kwm(string k);
    if (wq.size() != k.len()) return 1'b0;
    for (int i = 0; i < k.len(); i++) if (lc(wq[i]) != k[i]) return 1'b0;
    return 1'b1;
  endfunction

  // 0 other, 1 begin, 2 end, 3 case, 4 endcase
  function automatic int classify(int inst);
    if (kwm("begin")) return 1;
    if (kwm("end")) return 2;
    if (ecase_of(inst) && kwm("case")) return 3;
    if (ecase_of(inst) && kwm("endcase")) return 4;
    return 0;
  endfunction

  function automatic void mapply(input int kind, input int maxd, inout int d,
                                 inout logic [31:0] st, inout bit e, inout logic [1:0] c);
    if (e) return;
    if (kind == 1 || kind == 3) begin
      if (d == maxd) begin e = 1'b1; c = 2'd3; end
      else begin st[d] = (kind == 3); d = d + 1; end
    end else if (kind == 2 || kind == 4) begin
      if (d == 0) begin e = 1'b1; c = 2'd1; end
      else if (st[d-1] != (kind == 4)) begin e = 1'b1; c = 2'd2; end
      else d = d - 1;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      wq.delete();
      for (int i = 0; i < 3; i++) begin md[i] = 0; mst[i] = '0; me[i] = 1'b0; mc[i] = 2'd0; end
    end else if (in_valid) begin
      if (in_b == 8'h20) begin
        if (wq.size() > 0)
          for (int i = 0; i < 3; i++) mapply(classify(i), maxd_of(i), md[i], mst[i], me[i], mc[i]);
        wq.delete();
      end else begin
        wq.push_back(in_b);
      end
    end
  end

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        int d;
        logic [31:0] s;
        bit e;
        logic [1:0] c;
        d = md[i]; s = mst[i]; e = me[i]; c = mc[i];
        if (wq.size() > 0) mapply(classify(i), maxd_of(i), d, s, e, c);
        check($sformatf("u%0d.result", i), res_w[i], (!e && d == 0));
        check($sformatf("u%0d.depth", i), dep_w[i], md[i]);
        check($sformatf("u%0d.error", i), err_w[i], me[i]);
        check($sformatf("u%0d.err_code", i), code_w[i], mc[i]);
      end
    end
  end

  task automatic put(logic [7:0] c, bit rnd_idle);
    if (rnd_idle && $urandom_range(0, 9) == 0) begin
      @(negedge clk);
      in_b = 8'($urandom_range(0, 255));
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_b = c;
    in_valid = 1'b1;
  endtask

  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) put(s[i], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_b = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  string words [8] = '{"begin", "end", "case", "endcase", "BEGIN", "EndCase", "beginx", "en"};

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    do_reset();
    check("rst.depth", dep_w[0], 0);
    check("rst.error", err_w[0], 0);
    check("rst.err_code", code_w[0], 0);
    check("rst.result", res_w[0], 1);

    send("begin ");   check("t1.d1", dep_w[0], 1);
    send("case ");    check("t1.d2", dep_w[0], 2);
    send("endcase "); check("t1.d3", dep_w[0], 1);
    send("end ");     check("t1.d4", dep_w[0], 0);
    check("t1.result", res_w[0], 1);
    check("t1.error", err_w[0], 0);

    do_reset();
    send("begin case end ");
    check("t2.error", err_w[0], 1);
    check("t2.code", code_w[0], 2);
    check("t2.depth", dep_w[0], 2);
    send("endcase end ");
    check("t2.result", res_w[0], 0);
    check("t2.depth_frozen", dep_w[0], 2);

    do_reset();
    send("end ");
    check("t3.code", code_w[0], 1);
    check("t3.depth", dep_w[0], 0);
    check("t3.result", res_w[0], 0);
    send("begin ");
    check("t3.ignored", dep_w[0], 0);

    do_reset();
    send("BeGiN EnD");
    check("t4.depth", dep_w[0], 1);
    check("t4.lookahead", res_w[0], 1);
    send(" x");
    check("t4.depth2", dep_w[0], 0);
    check("t4.result2", res_w[0], 1);

    do_reset();
    send("begin  begin beginx ");
    check("t5.depth", dep_w[1], 2);
    check("t5.noerr", err_w[1], 0);
    send("begin ");
    check("t5.code", code_w[1], 3);
    check("t5.held", dep_w[1], 2);
    send("beg");
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_b = "i";
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check("t5.rst_depth", dep_w[1], 0);
    check("t5.rst_error", err_w[1], 0);
    check("t5.rst_result", res_w[1], 1);

    do_reset();
    send("case ");
    check("t6.case_ignored", dep_w[2], 0);
    check("t6.noerr", err_w[2], 0);
    send("end ");
    check("t6.code", code_w[2], 1);

    do_reset();
    send("begin");
    in_b = 8'h20;
    repeat (3) @(negedge clk);
    check("t7.hold_depth", dep_w[0], 0);
    check("t7.hold_result", res_w[0], 0);
    send(" ");
    check("t7.commit", dep_w[0], 1);

    do_reset();
    for (int w = 0; w < 300; w++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      if ($urandom_range(0, 4) == 0) begin
        int n;
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) put(8'($urandom_range(33, 126)), 1'b1);
      end else begin
        string s;
        s = words[$urandom_range(0, 7)];
        for (int j = 0; j < s.len(); j++) put(s[j], 1'b1);
      end
      repeat ($urandom_range(1, 2)) put(8'h20, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
